// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles MSB-first bits into WIDTH-bit words
// and presents them on a held output with a valid/ack handshake and sticky overrun.
module sipo_rx #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             frame_sync,
    input  logic             dout_ack,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt
);

    // Handshake: a word transfers on any rising edge where dout_valid=1 and
    // dout_ack=1; dout_ack is ignored while dout_valid=0, and dout holds after transfer.

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic             word_done;
    logic [WIDTH-1:0] word;

    // frame_sync overrides any completion that would otherwise happen this edge
    assign word_done = sin_en && !frame_sync && (bit_cnt == LAST_BIT);
    assign word      = {sr[WIDTH-2:0], sin};
    assign busy      = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (frame_sync) begin
                if (sin_en) begin
                    sr      <= {{(WIDTH-1){1'b0}}, sin};
                    bit_cnt <= CNT_W'(1);
                    state   <= SHIFT;
                end else begin
                    sr      <= '0;
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
            end else if (sin_en) begin
                sr <= word;
                if (word_done) begin
                    bit_cnt <= '0;
                    state   <= IDLE;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    state   <= SHIFT;
                end
            end

            if (ovr_clr) begin
                overrun <= 1'b0;
            end

            // A completion landing on a held, unacknowledged word is dropped
            if (word_done) begin
                if (!dout_valid || dout_ack) begin
                    dout       <= word;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ack) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx (WIDTH=4): hand-computed words pass through an
// expected queue; every comparison goes through check().
module tb_sipo_rx;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             clk;
    logic             rst;
    logic             sin;
    logic             sin_en;
    logic             frame_sync;
    logic             dout_ack;
    logic             ovr_clr;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             overrun;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    sipo_rx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_en     (sin_en),
        .frame_sync (frame_sync),
        .dout_ack   (dout_ack),
        .ovr_clr    (ovr_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun),
        .busy       (busy),
        .bit_cnt    (bit_cnt)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one enabled edge; inputs return to idle just after the edge
    task automatic send_bit(input logic b, input logic ack = 1'b0,
                            input logic clr = 1'b0, input logic fs = 1'b0);
        @(negedge clk);
        sin        = b;
        sin_en     = 1'b1;
        dout_ack   = ack;
        ovr_clr    = clr;
        frame_sync = fs;
        @(posedge clk);
        #1;
        sin_en     = 1'b0;
        dout_ack   = 1'b0;
        ovr_clr    = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    // disabled cycles with sin wiggling
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sin    = 1'(($urandom_range(0, 1)));
            sin_en = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        dout_ack = 1'b1;
        @(posedge clk);
        #1;
        dout_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        ovr_clr = 1'b1;
        @(posedge clk);
        #1;
        ovr_clr = 1'b0;
    endtask

    // scoreboard: compare dout with the oldest expected word
    task automatic check_word(input string tag);
        logic [WIDTH-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no expected word queued", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(dout), 32'(e));
        end
    endtask

    initial begin
        rst = 1'b1; sin = 1'b0; sin_en = 1'b0; frame_sync = 1'b0;
        dout_ack = 1'b0; ovr_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout",    32'(dout),       32'd0);
        check("rst_valid",   32'(dout_valid), 32'd0);
        check("rst_overrun", 32'(overrun),    32'd0);
        check("rst_cnt",     32'(bit_cnt),    32'd0);
        check("rst_busy",    32'(busy),       32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1. basic word 1011
        send_bit(1'b1); check("t1_cnt1", 32'(bit_cnt), 32'd1);
        send_bit(1'b0); check("t1_cnt2", 32'(bit_cnt), 32'd2);
        send_bit(1'b1); check("t1_cnt3", 32'(bit_cnt), 32'd3);
        check("t1_valid_early", 32'(dout_valid), 32'd0);
        send_bit(1'b1); check("t1_cnt0", 32'(bit_cnt), 32'd0);
        exp_q.push_back(4'b1011);
        check_word("t1_dout");
        check("t1_valid", 32'(dout_valid), 32'd1);
        check("t1_busy",  32'(busy),       32'd0);
        pulse_ack();
        check("t1_valid_ack", 32'(dout_valid), 32'd0);
        check("t1_dout_hold", 32'(dout),       32'hB);
        pulse_ack();
        check("t1_ack_idle", 32'(dout_valid), 32'd0);

        // 2. gapped 1100
        send_bit(1'b1); gap(3); check("t2_busy1", 32'(busy), 32'd1);
        check("t2_cnt1", 32'(bit_cnt), 32'd1);
        send_bit(1'b1); gap(3); check("t2_busy2", 32'(busy), 32'd1);
        send_bit(1'b0); gap(3); check("t2_busy3", 32'(busy), 32'd1);
        check("t2_cnt3", 32'(bit_cnt), 32'd3);
        check("t2_valid_early", 32'(dout_valid), 32'd0);
        send_bit(1'b0);
        exp_q.push_back(4'b1100);
        check_word("t2_dout");
        check("t2_valid", 32'(dout_valid), 32'd1);
        check("t2_busy_done", 32'(busy), 32'd0);
        pulse_ack();

        // 3. back-to-back: 0110 unacked, then 1001 completing with ack
        send_word(4'b0110);
        check("t3_first", 32'(dout), 32'h6);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1, 1'b1);
        exp_q.push_back(4'b1001);
        check_word("t3_dout");
        check("t3_valid",   32'(dout_valid), 32'd1);
        check("t3_overrun", 32'(overrun),    32'd0);
        pulse_ack();
        check("t3_valid_ack", 32'(dout_valid), 32'd0);

        // 4. overrun: 1111 held, 0001 dropped
        send_word(4'b1111);
        send_word(4'b0001);
        exp_q.push_back(4'b1111);
        check_word("t4_dout");
        check("t4_overrun", 32'(overrun),    32'd1);
        check("t4_valid",   32'(dout_valid), 32'd1);
        gap(3);
        check("t4_overrun_sticky", 32'(overrun), 32'd1);
        pulse_clr();
        check("t4_overrun_clr", 32'(overrun),    32'd0);
        check("t4_valid_clr",   32'(dout_valid), 32'd1);
        check("t4_dout_clr",    32'(dout),       32'hF);
        pulse_ack();

        // 5. frame_sync mid-word
        send_bit(1'b1); send_bit(1'b0);
        check("t5_cnt2", 32'(bit_cnt), 32'd2);
        send_bit(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_sync_cnt", 32'(bit_cnt), 32'd1);
        check("t5_sync_valid", 32'(dout_valid), 32'd0);
        send_bit(1'b1); send_bit(1'b0);
        check("t5_cnt3", 32'(bit_cnt), 32'd3);
        check("t5_valid_early", 32'(dout_valid), 32'd0);
        send_bit(1'b1);
        exp_q.push_back(4'b0101);
        check_word("t5_dout");
        check("t5_valid", 32'(dout_valid), 32'd1);
        pulse_ack();

        // 6. async reset mid-frame
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check("t6_cnt3", 32'(bit_cnt), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("t6_cnt",   32'(bit_cnt),    32'd0);
        check("t6_busy",  32'(busy),       32'd0);
        check("t6_dout",  32'(dout),       32'd0);
        check("t6_valid", 32'(dout_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_word(4'b1010);
        exp_q.push_back(4'b1010);
        check_word("t6_dout_after");
        check("t6_valid_after", 32'(dout_valid), 32'd1);

        // ovr_clr coinciding with a new overrun: set wins
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        check("t7_set_wins", 32'(overrun), 32'd1);
        check("t7_dout",     32'(dout),    32'hA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
